// File: rtl/morse_tx.sv
// Morse transmitter: accepts one character code per handshake and keys its International Morse pattern.
// Optional `MORSE_TX_LED_EN` adds a led[2:0] port showing the current element/gap class.
module morse_tx #(
  parameter int unsigned CLK_DIV          = 4,
  parameter int unsigned DASH_UNITS       = 3,
  parameter int unsigned LETTER_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS   = 7
) (
  input  logic       clk_board,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [4:0] in_char,
  output logic       in_ready,
  output logic       morse_out,
  output logic [1:0] sym_type,
  output logic       busy,
  output logic       err
`ifdef MORSE_TX_LED_EN
  ,
  output logic [2:0] led
`endif
);

  localparam int unsigned DOT_CYC  = CLK_DIV;
  localparam int unsigned DASH_CYC = DASH_UNITS * CLK_DIV;
  localparam int unsigned LGAP_CYC = LETTER_GAP_UNITS * CLK_DIV;
  localparam int unsigned WGAP_CYC = WORD_GAP_UNITS * CLK_DIV;
  localparam int unsigned MAX_A    = (DASH_CYC > LGAP_CYC) ? DASH_CYC : LGAP_CYC;
  localparam int unsigned MAX_CYC  = (WGAP_CYC > MAX_A) ? WGAP_CYC : MAX_A;
  localparam int unsigned CW       = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DOT_LD  = CW'(DOT_CYC - 1);
  localparam logic [CW-1:0] DASH_LD = CW'(DASH_CYC - 1);
  localparam logic [CW-1:0] LGAP_LD = CW'(LGAP_CYC - 1);
  localparam logic [CW-1:0] WGAP_LD = CW'(WGAP_CYC - 1);

  localparam logic [1:0] SYM_GAP  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_STOP = 2'b11;

  localparam logic [4:0] CODE_WORD = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_LGAP,
    S_WGAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [2:0]    len;
  logic [3:0]    pat;
  logic [2:0]    rom_len_c;
  logic [3:0]    rom_pat_c;
  logic          last_c;
  logic          is_letter_c;

  assign in_ready    = (state == S_IDLE);
  assign is_letter_c = (in_char < CODE_WORD);
  assign last_c      = (({1'b0, idx} + 3'd1) == len);

  // Pattern ROM: length 1-4, elements left-justified MSB-first, 1 = dash
  always_comb begin
    rom_len_c = 3'd0;
    rom_pat_c = 4'b0000;
    case (in_char)
      5'd0:    {rom_len_c, rom_pat_c} = {3'd2, 4'b0100};
      5'd1:    {rom_len_c, rom_pat_c} = {3'd4, 4'b1000};
      5'd2:    {rom_len_c, rom_pat_c} = {3'd4, 4'b1010};
      5'd3:    {rom_len_c, rom_pat_c} = {3'd3, 4'b1000};
      5'd4:    {rom_len_c, rom_pat_c} = {3'd1, 4'b0000};
      5'd5:    {rom_len_c, rom_pat_c} = {3'd4, 4'b0010};
      5'd6:    {rom_len_c, rom_pat_c} = {3'd3, 4'b1100};
      5'd7:    {rom_len_c, rom_pat_c} = {3'd4, 4'b0000};
      5'd8:    {rom_len_c, rom_pat_c} = {3'd2, 4'b0000};
      5'd9:    {rom_len_c, rom_pat_c} = {3'd4, 4'b0111};
      5'd10:   {rom_len_c, rom_pat_c} = {3'd3, 4'b1010};
      5'd11:   {rom_len_c, rom_pat_c} = {3'd4, 4'b0100};
      5'd12:   {rom_len_c, rom_pat_c} = {3'd2, 4'b1100};
      5'd13:   {rom_len_c, rom_pat_c} = {3'd2, 4'b1000};
      5'd14:   {rom_len_c, rom_pat_c} = {3'd3, 4'b1110};
      5'd15:   {rom_len_c, rom_pat_c} = {3'd4, 4'b0110};
      5'd16:   {rom_len_c, rom_pat_c} = {3'd4, 4'b1101};
      5'd17:   {rom_len_c, rom_pat_c} = {3'd3, 4'b0100};
      5'd18:   {rom_len_c, rom_pat_c} = {3'd3, 4'b0000};
      5'd19:   {rom_len_c, rom_pat_c} = {3'd1, 4'b1000};
      5'd20:   {rom_len_c, rom_pat_c} = {3'd3, 4'b0010};
      5'd21:   {rom_len_c, rom_pat_c} = {3'd4, 4'b0001};
      5'd22:   {rom_len_c, rom_pat_c} = {3'd3, 4'b0110};
      5'd23:   {rom_len_c, rom_pat_c} = {3'd4, 4'b1001};
      5'd24:   {rom_len_c, rom_pat_c} = {3'd4, 4'b1011};
      5'd25:   {rom_len_c, rom_pat_c} = {3'd4, 4'b1100};
      default: {rom_len_c, rom_pat_c} = {3'd0, 4'b0000};
    endcase
  end

  // Keying FSM; the duration counter reloads on every state entry and counts down to 0
  always_ff @(posedge clk_board) begin
    if (clear) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 2'd0;
      len       <= 3'd0;
      pat       <= 4'b0000;
      morse_out <= 1'b0;
      sym_type  <= SYM_STOP;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sym_type <= SYM_STOP;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_letter_c) begin
              state     <= S_MARK;
              len       <= rom_len_c;
              pat       <= rom_pat_c;
              idx       <= 2'd0;
              morse_out <= 1'b1;
              busy      <= 1'b1;
              sym_type  <= rom_pat_c[3] ? SYM_DASH : SYM_DOT;
              cnt       <= rom_pat_c[3] ? DASH_LD : DOT_LD;
            end else if (in_char == CODE_WORD) begin
              state    <= S_WGAP;
              busy     <= 1'b1;
              sym_type <= SYM_GAP;
              cnt      <= WGAP_LD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_MARK: begin
          if (cnt == '0) begin
            morse_out <= 1'b0;
            if (last_c) begin
              state    <= S_LGAP;
              sym_type <= SYM_GAP;
              cnt      <= LGAP_LD;
            end else begin
              state <= S_SPACE;
              pat   <= {pat[2:0], 1'b0};
              cnt   <= DOT_LD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SPACE: begin
          if (cnt == '0) begin
            state     <= S_MARK;
            idx       <= idx + 2'd1;
            morse_out <= 1'b1;
            sym_type  <= pat[3] ? SYM_DASH : SYM_DOT;
            cnt       <= pat[3] ? DASH_LD : DOT_LD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_LGAP, S_WGAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          morse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MORSE_TX_LED_EN
  // Level indication held for the whole state: 001 dot, 011 dash, 111 gap, 000 otherwise
  always_ff @(posedge clk_board) begin
    if (clear) begin
      led <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_letter_c)               led <= rom_pat_c[3] ? 3'b011 : 3'b001;
            else if (in_char == CODE_WORD) led <= 3'b111;
            else                           led <= 3'b000;
          end
        end
        S_MARK:  if (cnt == '0) led <= last_c ? 3'b111 : 3'b000;
        S_SPACE: if (cnt == '0) led <= pat[3] ? 3'b011 : 3'b001;
        S_LGAP, S_WGAP: if (cnt == '0) led <= 3'b000;
        default: led <= 3'b000;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: a driver predicts per-cycle outputs from Morse strings, a monitor compares.
module tb_morse_tx;

  localparam int unsigned CD = 4;
  localparam int unsigned DU = 3;
  localparam int unsigned LG = 3;
  localparam int unsigned WG = 7;

  localparam logic [1:0] GAP  = 2'b00;
  localparam logic [1:0] DOT  = 2'b01;
  localparam logic [1:0] DASH = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  typedef struct packed {
    logic       mo;
    logic [1:0] sym;
    logic       busy;
    logic       err;
    logic       rdy;
  } rec_t;

  logic       clk_board = 1'b0;
  logic       clear     = 1'b1;
  logic       in_valid  = 1'b0;
  logic [4:0] in_char   = 5'd0;
  logic       in_ready;
  logic       morse_out;
  logic [1:0] sym_type;
  logic       busy;
  logic       err;

  rec_t exp_q[$];
  rec_t pend[$];
  rec_t last_rec;
  int   checks = 0;
  int   errors = 0;

  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  always #5 clk_board = ~clk_board;

  morse_tx #(
    .CLK_DIV(CD),
    .DASH_UNITS(DU),
    .LETTER_GAP_UNITS(LG),
    .WORD_GAP_UNITS(WG)
  ) dut (
    .clk_board(clk_board),
    .clear(clear),
    .in_valid(in_valid),
    .in_char(in_char),
    .in_ready(in_ready),
    .morse_out(morse_out),
    .sym_type(sym_type),
    .busy(busy),
    .err(err)
  );

  function automatic rec_t mk(logic mo, logic [1:0] sym, logic b, logic e, logic r);
    rec_t x;
    x.mo = mo; x.sym = sym; x.busy = b; x.err = e; x.rdy = r;
    return x;
  endfunction

  function automatic rec_t idle_rec();
    return mk(1'b0, STOP, 1'b0, 1'b0, 1'b1);
  endfunction

  // Expected output of every cycle following the transfer edge, from the Morse string
  task automatic build_seq(input logic [4:0] c);
    string s;
    int    n;
    pend.delete();
    if (c < 5'd26) begin
      s = MORSE[c];
      for (int i = 0; i < s.len(); i++) begin
        n = (s[i] == "-") ? int'(DU * CD) : int'(CD);
        for (int j = 0; j < n; j++)
          pend.push_back(mk(1'b1, (j == 0) ? ((s[i] == "-") ? DASH : DOT) : STOP, 1'b1, 1'b0, 1'b0));
        if (i < s.len() - 1)
          for (int j = 0; j < int'(CD); j++) pend.push_back(mk(1'b0, STOP, 1'b1, 1'b0, 1'b0));
      end
      for (int j = 0; j < int'(LG * CD); j++)
        pend.push_back(mk(1'b0, (j == 0) ? GAP : STOP, 1'b1, 1'b0, 1'b0));
    end else if (c == 5'd26) begin
      for (int j = 0; j < int'(WG * CD); j++)
        pend.push_back(mk(1'b0, (j == 0) ? GAP : STOP, 1'b1, 1'b0, 1'b0));
    end else begin
      pend.push_back(mk(1'b0, STOP, 1'b0, 1'b1, 1'b1));
    end
  endtask

  // One cycle of stimulus; pushes what the DUT must show after the coming edge
  task automatic step(input bit v, input logic [4:0] c, input bit clr);
    @(negedge clk_board);
    clear    = clr;
    in_valid = v;
    in_char  = c;
    if (clr) begin
      pend.delete();
      last_rec = idle_rec();
    end else if (last_rec.rdy && v) begin
      build_seq(c);
      last_rec = pend.pop_front();
    end else if (pend.size() != 0) begin
      last_rec = pend.pop_front();
    end else begin
      last_rec = idle_rec();
    end
    exp_q.push_back(last_rec);
  endtask

  // Waits out any transmission with random ignored in_valid traffic, then transfers c
  task automatic send(input logic [4:0] c);
    while (!last_rec.rdy) step(1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
    step(1'b1, c, 1'b0);
  endtask

  task automatic send_held(input logic [4:0] c);
    while (!last_rec.rdy) step(1'b1, c, 1'b0);
    step(1'b1, c, 1'b0);
  endtask

  initial begin : monitor
    rec_t e;
    rec_t a;
    forever begin
      @(posedge clk_board);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = mk(morse_out, sym_type, busy, err, in_ready);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t: got mo=%b sym=%b busy=%b err=%b rdy=%b, expected mo=%b sym=%b busy=%b err=%b rdy=%b",
                   $time, a.mo, a.sym, a.busy, a.err, a.rdy, e.mo, e.sym, e.busy, e.err, e.rdy);
        end
      end
    end
  end

  initial begin : driver
    last_rec = idle_rec();
    step(1'b1, 5'd4, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0);
    send(5'd4);
    step(1'b0, 5'd0, 1'b0);
    send(5'd0);
    send(5'd26);
    send(5'd30);
    step(1'b0, 5'd0, 1'b0);
    send(5'd19);
    send_held(5'd12);
    send(5'd16);
    repeat (34) step(1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
    step(1'b0, 5'd0, 1'b1);
    send(5'd4);
    for (int k = 0; k < 26; k++) send(5'(k));
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) step(1'b0, 5'd0, 1'b1);
      else        step(r < 60, 5'($urandom), 1'b0);
    end
    step(1'b0, 5'd0, 1'b0);
    @(posedge clk_board);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
- Transmit-side counterpart of the switch-driven Morse input classifier.
- Accepts one character code per handshake, looks up its International Morse pattern and drives a timed on/off keying output (LED or buzzer).
- Emits the same GAP/DOT/DASH/STOP symbol codes the receive path uses, so a board can loop transmit back into receive.
- Timing is derived from clk_board through an internal unit-tick divider.

Parameters:
- CLK_DIV, 4, clk_board cycles per Morse time unit (>=1).
- DASH_UNITS, 3, dash mark length in units.
- LETTER_GAP_UNITS, 3, quiet time after a letter's last element, in units.
- WORD_GAP_UNITS, 7, quiet time for the word-space code, in units.

Ports:
- clk_board  in  1  system clock; everything in this block is on clk_board.
- clear  in  1  reset; synchronous and active-high.
- in_valid  in  1  char is valid.
- in_char  in  5  character code: 0-25 = A-Z, 26 = word space, 27-31 = invalid.
- in_ready  out  1  block can accept a character.
- morse_out  out  1  keying output: 1 = mark, 0 = space.
- sym_type  out  2  one-cycle symbol strobe: 00 GAP, 01 DOT, 10 DASH, 11 STOP (idle value).
- busy  out  1  transmission in progress.
- err  out  1  one-cycle pulse when an invalid code is accepted.

Behaviour:
- Reset (clear=1 at a clk_board edge):
  - State IDLE, all counters 0.
  - morse_out=0, sym_type=STOP, busy=0, err=0, in_ready=1 after that edge.
  - Clearing mid-transmission aborts immediately; the partial character is discarded.
- Handshake:
  - Transfer occurs on an edge where in_valid&in_ready.
  - in_ready = (state==IDLE); it is combinational from the registered state.
  - in_valid while busy is ignored; nothing is queued.
  - in_char is sampled only at the transfer edge.
- Pattern ROM (combinational, 3-bit length 1-4, 4-bit pattern MSB-first, 1 = dash):
  - A .- / B -... / C -.-. / D -.. / E . / F ..-. / G --. / H .... / I .. / J .--- / K -.- / L .-.. / M --
  - N -. / O --- / P .--. / Q --.- / R .-. / S ... / T - / U ..- / V ...- / W .-- / X -..- / Y -.-- / Z --..
- States:
  - IDLE: waits for a transfer. Valid letter -> MARK with element index 0. Code 26 -> WGAP. Code 27-31 -> err=1 for one cycle, stay IDLE, in_ready stays 1.
  - MARK: morse_out=1 for CLK_DIV cycles (dot) or DASH_UNITS*CLK_DIV cycles (dash). Then -> SPACE if elements remain, else -> LGAP.
  - SPACE: morse_out=0 for CLK_DIV cycles, then -> MARK on the next element.
  - LGAP: morse_out=0 for LETTER_GAP_UNITS*CLK_DIV cycles, then -> IDLE.
  - WGAP: morse_out=0 for WORD_GAP_UNITS*CLK_DIV cycles, then -> IDLE.
- Timing:
  - morse_out, sym_type, busy and err are registered.
  - The first mark cycle is the cycle immediately after the transfer edge; latency is 1.
  - The duration counter reloads on every state entry; there is no free-running tick phase, so timing is deterministic.
  - busy=1 in every state except IDLE.
- sym_type strobes:
  - DOT or DASH for exactly the first cycle of each MARK.
  - GAP for the first cycle of LGAP and of WGAP.
  - STOP at all other times.
- Width rules:
  - The duration counter is wide enough for WORD_GAP_UNITS*CLK_DIV.
  - The element index is 2 bits and never wraps past the pattern length.
- Back-to-back: in_valid held high with a new char transfers on the first IDLE cycle after LGAP/WGAP ends. The one IDLE cycle adds one extra space cycle between letters.

Optional Feature:
- MORSE_TX_LED_EN defined:
  - Adds output port led[2:0], mirroring the receive-side indication: 000 idle/STOP, 001 during a dot mark, 011 during a dash mark, 111 during LGAP/WGAP. Held for the whole state, not strobed.
  - led resets to 000.
- Undefined: the led port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then char 4 ('E'), CLK_DIV=4 -> morse_out=1 for 4 cycles then 0 for 12 cycles; sym_type DOT on cycle 1 and GAP on cycle 5; in_ready=1 again on cycle 17; busy=1 for cycles 1-16.
- Char 0 ('A') -> morse_out 1x4, 0x4, 1x12, 0x12; sym_type DOT at cycle 1, DASH at cycle 9, GAP at cycle 21; 32 busy cycles.
- Char 26 -> morse_out stays 0; GAP strobe on cycle 1; busy for 28 cycles.
- Char 30 -> err=1 for one cycle, morse_out=0, busy=0, in_ready stays 1.
- 'T' then 'M' with in_valid held high -> 'M' accepted exactly one IDLE cycle after T's 12-cycle LGAP; any in_valid pulses during T are ignored.
- clear asserted during the 3rd element of 'Q' -> next edge morse_out=0, sym_type=STOP, in_ready=1; next char 'E' produces normal timing.
